// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REQ_ADDR_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  function automatic logic is_aligned(input logic [REQ_ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write, registered read.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder with pipeline stall and flush handling.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic                  req_wr,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  stall
);

  localparam logic [3:0] CountInit = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              aligned, accept, enter_resp, load_done;
  logic [DATA_W-1:0] arr_rdata;
  logic              unused_addr;

  assign aligned     = is_aligned(req_addr);
  assign accept      = (state_q == StIdle) && req_valid && !flush && aligned;
  assign unused_addr = ^req_addr[REQ_ADDR_W-1:ADDR_W+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          count_d = CountInit;
          state_d = (CountInit == 4'd0) ? StResp : StBusy;
        end
      end
      StBusy: begin
        count_d = count_q - 4'd1;
        // Stores already accepted must commit, so only loads abort on flush.
        if (flush && !wr_q) begin
          state_d = StIdle;
        end else if (count_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Array is driven from the *_d values so LATENCY=1 can write/read on the acceptance edge.
  always_comb begin
    wr_d       = accept ? req_wr : wr_q;
    idx_d      = accept ? req_addr[ADDR_W+1:2] : idx_q;
    wdata_d    = accept ? req_wdata : wdata_q;
    err_d      = (state_q == StIdle) && req_valid && !flush && !aligned;
    enter_resp = (state_d == StResp) && (state_q != StResp);
    load_done  = (state_q == StResp) && !wr_q && !flush;
    rdata_d    = load_done ? arr_rdata : rdata_q;
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp) && !flush;
    resp_err   = err_q;
    stall      = (state_q == StBusy) || accept;
    resp_rdata = load_done ? arr_rdata : rdata_q;
  end

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (enter_resp && wr_d),
    .re   (enter_resp && !wr_d),
    .addr (idx_d),
    .wdata(wdata_d),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY=2 and LATENCY=1) against a timeline model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        flush      [2];
  logic        req_valid  [2];
  logic        req_wr     [2];
  logic [15:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        stall      [2];

  int checks = 0;
  int failures = 0;

  logic [31:0] mem  [2][64];
  logic [31:0] last [2];
  int          lat  [2] = '{2, 1};

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(6), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst[0]), .flush(flush[0]), .req_valid(req_valid[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .stall(stall[0])
  );

  dmem_responder #(.ADDR_W(6), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .flush(flush[1]), .req_valid(req_valid[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .stall(stall[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cycle(input int d, input string tag, input logic er, input logic es,
                             input logic ev, input logic ee, input logic [31:0] erd);
    chk($sformatf("d%0d %s req_ready", d, tag), {31'b0, req_ready[d]}, {31'b0, er});
    chk($sformatf("d%0d %s stall", d, tag), {31'b0, stall[d]}, {31'b0, es});
    chk($sformatf("d%0d %s resp_valid", d, tag), {31'b0, resp_valid[d]}, {31'b0, ev});
    chk($sformatf("d%0d %s resp_err", d, tag), {31'b0, resp_err[d]}, {31'b0, ee});
    chk($sformatf("d%0d %s resp_rdata", d, tag), resp_rdata[d], erd);
  endtask

  // Entered and left at posedge+1 with the DUT idle. fl: cycle after acceptance to assert flush.
  task automatic run_req(input int d, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input int fl, input logic iflush);
    int          l;
    int          idx;
    logic        al;
    logic        f;
    logic [31:0] exp_rd;
    l   = lat[d];
    idx = int'(addr[7:2]);
    al  = (addr[1:0] == 2'b00);
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    flush[d]     = iflush;
    @(negedge clk);
    check_cycle(d, "accept", 1'b1, al && !iflush, 1'b0, 1'b0, last[d]);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    flush[d]     = 1'b0;
    if (iflush || !al) begin
      for (int c = 1; c <= l + 1; c++) begin
        @(negedge clk);
        check_cycle(d, "no-accept", 1'b1, 1'b0, 1'b0, (c == 1) && !al && !iflush, last[d]);
        @(posedge clk); #1;
      end
      return;
    end
    for (int c = 1; c <= l; c++) begin
      f = (c == fl);
      flush[d] = f;
      @(negedge clk);
      if (c < l) begin
        check_cycle(d, "busy", 1'b0, 1'b1, 1'b0, 1'b0, last[d]);
      end else begin
        if (wr) mem[d][idx] = wdata;
        exp_rd = (!wr && !f) ? mem[d][idx] : last[d];
        check_cycle(d, "resp", 1'b0, 1'b0, !f, 1'b0, exp_rd);
        last[d] = exp_rd;
      end
      @(posedge clk); #1;
      flush[d] = 1'b0;
      if (f && !wr) break;
    end
    @(negedge clk);
    check_cycle(d, "done", 1'b1, 1'b0, 1'b0, 1'b0, last[d]);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          d;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          fl;
    logic        iflush;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] old;
    int          d;
    logic [15:0] a;

    vecs.push_back('{0, 1'b1, 16'h0010, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 16'h0010, 32'h0, 0, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b0, 16'h0012, 32'h0, 0, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 16'h0011, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 16'h0010, 32'h0, 0, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 16'h0020, 32'h5555AAAA, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 16'h0020, 32'h0, 1, 1'b0, 1'b1, 32'hDEADBEEF});
    vecs.push_back('{0, 1'b1, 16'h00FC, 32'h1, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 16'h01FC, 32'h0, 0, 1'b0, 1'b1, 32'h1});
    vecs.push_back('{1, 1'b1, 16'h00FC, 32'h1, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 16'h01FC, 32'h0, 0, 1'b0, 1'b1, 32'h1});
    vecs.push_back('{0, 1'b1, 16'h0030, 32'h12345678, 0, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 16'h0030, 32'h0, 0, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b1, 16'h0034, 32'hA5A5A5A5, 2, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 16'h0034, 32'h0, 0, 1'b0, 1'b1, 32'hA5A5A5A5});
    vecs.push_back('{0, 1'b0, 16'h0020, 32'h0, 2, 1'b0, 1'b1, 32'hA5A5A5A5});
    vecs.push_back('{1, 1'b0, 16'h0020, 32'h0, 1, 1'b0, 1'b1, 32'h1});

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; flush[i] = 1'b0; req_valid[i] = 1'b0; req_wr[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; last[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_cycle(i, "reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    @(posedge clk); #1;

    // Give every word a known value so later loads have defined expectations.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++) begin
        run_req(i, 1'b1, 16'(w * 4), $urandom, 0, 1'b0);
      end
    end

    foreach (vecs[i]) begin
      run_req(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].fl, vecs[i].iflush);
      if (vecs[i].chk_rd) begin
        chk($sformatf("vec%0d rdata", i), resp_rdata[vecs[i].d], vecs[i].exp_rd);
      end
    end

    // Reset while a store sits in BUSY: the store must be lost.
    old = mem[0][16];
    req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 16'h0040; req_wdata[0] = ~old;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("rst pre stall", {31'b0, stall[0]}, 32'h1);
    #1 rst[0] = 1'b0;
    #1;
    check_cycle(0, "async-reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    last[0] = '0;
    run_req(0, 1'b0, 16'h0040, 32'h0, 0, 1'b0);
    chk("rst lost store", resp_rdata[0], old);

    for (int i = 0; i < 300; i++) begin
      d = int'($urandom_range(0, 1));
      a = 16'($urandom);
      if (($urandom % 4) != 0) a[1:0] = 2'b00;
      run_req(d, 1'($urandom), a, $urandom,
              (($urandom % 4) == 0) ? int'($urandom_range(1, lat[d])) : 0,
              1'(($urandom % 10) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
